// File: rtl/scmi_mbox_arb_pkg.sv
// Shared types and constants for the SCMI mailbox channel arbiter.
package scmi_mbox_arb_pkg;

  localparam int unsigned N_AGENTS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_CMPL = 2'd2
  } scmi_arb_state_e;

  // Owner index width; never below one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scmi_rr_picker.sv
// Combinational round-robin picker: first requester at or after last_i+1, wrapping.
module scmi_rr_picker
  import scmi_mbox_arb_pkg::*;
#(
  parameter int unsigned N_AGENTS = N_AGENTS_DEF,
  localparam int unsigned ID_W = id_w(N_AGENTS)
) (
  input  logic [N_AGENTS-1:0] req_i,
  input  logic [ID_W-1:0]     last_i,
  output logic [ID_W-1:0]     winner_o,
  output logic                any_o
);

  logic [ID_W-1:0] cand;

  // Walk from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    winner_o = '0;
    cand     = '0;
    any_o    = |req_i;
    for (int unsigned i = N_AGENTS; i >= 1; i--) begin
      cand = ID_W'((32'(last_i) + i) % N_AGENTS);
      if (req_i[cand]) winner_o = cand;
    end
  end

endmodule

// File: rtl/scmi_mbox_arbiter.sv
// Round-robin ownership arbiter for one SCMI mailbox channel shared by N_AGENTS.
// Define SCMI_MBOX_ARB_TIMEOUT_EN to build the WAIT_CMPL forced-release timer.
module scmi_mbox_arbiter
  import scmi_mbox_arb_pkg::*;
#(
  parameter int unsigned N_AGENTS       = N_AGENTS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned ID_W = id_w(N_AGENTS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_AGENTS-1:0] req_i,
  output logic [N_AGENTS-1:0] gnt_o,
  input  logic                doorbell_i,
  input  logic                completion_i,
  output logic [N_AGENTS-1:0] done_o,
  output logic [N_AGENTS-1:0] timeout_o,
  output logic [ID_W-1:0]     owner_o,
  output logic                busy_o
);

  if (N_AGENTS < 2 || N_AGENTS > 16) begin : g_bad_n_agents
    $error("scmi_mbox_arbiter: N_AGENTS must be in 2..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("scmi_mbox_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  scmi_arb_state_e     state_q, state_d;
  logic [N_AGENTS-1:0] gnt_q, gnt_d;
  logic [N_AGENTS-1:0] done_q, done_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     winner;
  logic                any_req;

`ifdef SCMI_MBOX_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_AGENTS-1:0] tmo_q, tmo_d;
`endif

  scmi_rr_picker #(.N_AGENTS(N_AGENTS)) u_picker (
    .req_i    (req_i),
    .last_i   (last_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    owner_d = owner_q;
    last_d  = last_q;
    busy_d  = busy_q;
`ifdef SCMI_MBOX_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          owner_d = winner;
          last_d  = winner;
          gnt_d   = N_AGENTS'(1) << winner;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        // Doorbell beats a same-cycle request drop.
        if (doorbell_i) begin
          state_d = WAIT_CMPL;
`ifdef SCMI_MBOX_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (!req_i[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      WAIT_CMPL: begin
        // Completion beats a same-cycle timeout expiry.
        if (completion_i) begin
          state_d = IDLE;
          done_d  = gnt_q;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
`ifdef SCMI_MBOX_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          tmo_d   = gnt_q;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      owner_q <= '0;
      last_q  <= ID_W'(N_AGENTS - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SCMI_MBOX_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tmo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign timeout_o = tmo_q;
`else
  assign timeout_o = '0;
`endif

  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign owner_o = owner_q;
  assign busy_o  = busy_q;

endmodule

// File: doc/scmi_mbox_arbiter.md
# scmi_mbox_arbiter

Shares a single SCMI mailbox channel, one shared-memory block with doorbell and completion interrupts, between `N_AGENTS` requesting agents. Grants exclusive channel ownership to one agent at a time, using round-robin order. Holds ownership across the whole doorbell → completion transaction, then releases the channel. Sits beside the AXI-Lite SCMI mailbox and consumes its `doorbell_irq_o` / `completion_irq_o` pulses.

## Interface
- `N_AGENTS`, default 4: number of requesting agents, range 2..16.
- `TIMEOUT_CYCLES`, default 1024: cycles allowed in WAIT_CMPL before forced release; must be ≥ 2.
- `ID_W`, derived localparam: `$clog2(N_AGENTS)`.

Ports (clock and reset first):
- `clk_i`  in  1: clock.
- `rst_i`  in  1: reset, synchronous, active-high.
- `req_i`  in  N_AGENTS: per-agent level request for the channel.
- `gnt_o`  out  N_AGENTS: one-hot ownership grant; at most one bit set.
- `doorbell_i`  in  1: single-cycle pulse from the mailbox doorbell interrupt.
- `completion_i`  in  1: single-cycle pulse from the mailbox completion interrupt.
- `done_o`  out  N_AGENTS: one-cycle pulse to the owner when its transaction completes.
- `timeout_o`  out  N_AGENTS: one-cycle pulse to the owner on forced release. Tied to 0 without the macro.
- `owner_o`  out  ID_W: index of the current owner; valid only while `busy_o` is high.
- `busy_o`  out  1: channel is owned (state GRANT or WAIT_CMPL).

## Operation
States: IDLE, GRANT, WAIT_CMPL.
- **IDLE:** if any `req_i` bit is set, pick the winner round-robin, starting at `last_owner+1` mod N_AGENTS. Register the winner in `owner_o` and `last_owner`, then go to GRANT.
- **GRANT:** `gnt_o[owner]`=1.
  - `doorbell_i` → WAIT_CMPL.
  - Else if `req_i[owner]`=0 → IDLE (voluntary release, no `done_o`).
- **WAIT_CMPL:** `gnt_o[owner]` stays 1 and `req_i` is ignored.
  - `completion_i` → pulse `done_o[owner]`, go to IDLE.
- The following are ignored:
  - `doorbell_i` in IDLE or WAIT_CMPL.
  - `completion_i` in IDLE or GRANT.
- Simultaneous events:
  - In GRANT, `doorbell_i` together with a `req_i[owner]` drop → doorbell wins, go to WAIT_CMPL.
  - In WAIT_CMPL, `completion_i` in the same cycle the timeout expires → completion wins. Pulse `done_o` only; no `timeout_o`.
- Round-robin pointer: `last_owner` resets to N_AGENTS-1, so agent 0 wins first after reset. A voluntary release still advances the pointer.

## Timing
- Reset values:
  - state=IDLE
  - `gnt_o`=0, `done_o`=0, `timeout_o`=0, `owner_o`=0, `busy_o`=0
  - `last_owner`=N_AGENTS-1
  - timeout counter=0
- All outputs are registered.
- Grant latency: `req_i` sampled high in IDLE at cycle t → `gnt_o` high at t+1.
- Release handover:
  - `done_o` pulses in the cycle after `completion_i`, and `gnt_o` falls in that same cycle.
  - The FSM spends at least one cycle in IDLE.
  - The next `gnt_o` rises no earlier than 2 cycles after `completion_i`.
- The `busy_o` deassertion cycle equals the `gnt_o` fall cycle.
- Reset asserted mid-transaction clears everything on the next edge. No `done_o` or `timeout_o` is emitted.

## Configuration
- Macro `SCMI_MBOX_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to WAIT_CMPL and increments each cycle in WAIT_CMPL.
  - When it reaches `TIMEOUT_CYCLES` without `completion_i`: pulse `timeout_o[owner]`, drop the grant, go to IDLE.
- **Undefined:** no counter is built, WAIT_CMPL waits indefinitely, and `timeout_o` is constant 0.

## Structure
- Package `scmi_mbox_arb_pkg` holds:
  - the state enum `scmi_arb_state_e` (IDLE, GRANT, WAIT_CMPL);
  - a default `N_AGENTS` constant;
  - the helper function for `ID_W`.
- Sub-module `scmi_rr_picker` is purely combinational. Inputs: request vector and last owner. Outputs: winner index and `any` flag.
- The FSM, registers and timeout counter live in `scmi_mbox_arbiter`.

## Test plan
- **Basic transaction:** N=4. `req_i`=0b0010 → `gnt_o`=0b0010 one cycle later, `owner_o`=1. `doorbell_i` pulse, then `completion_i` 5 cycles later → `done_o`=0b0010 for exactly 1 cycle, `gnt_o`=0, `busy_o`=0.
- **Round-robin fairness:** `req_i`=0b1111 held, complete each transaction. Grant order is 0,1,2,3,0, with exactly 1 IDLE cycle between grants.
- **Voluntary release:** agent 2 is granted and drops `req_i` before any doorbell. `gnt_o` falls the next cycle with no `done_o`. A pending agent 3 is granted one cycle later.
- **Simultaneous/spurious events:**
  - `doorbell_i` coincides with the owner's `req_i` drop in GRANT → state WAIT_CMPL, grant held.
  - `completion_i` in GRANT → ignored, grant held.
- **Timeout (macro defined, TIMEOUT_CYCLES=8):** doorbell with no completion → `timeout_o[owner]` pulses 8 cycles after entering WAIT_CMPL, grant dropped. Completion landing on cycle 8 → `done_o` only, no `timeout_o`.
- **Reset mid-WAIT_CMPL:** `rst_i` held 1 cycle → all outputs 0 next cycle. The next request from any agent grants agent 0 first, when it is requesting.
